// File: rtl/sweep_pkg.sv
// Constants and state encoding for the 16:1 sweep select path.
// The mux-side sweep generator uses the same constants.
package sweep_pkg;

    // N must equal 2**SEL_W so that the slot counter wraps exactly at N-1.
    localparam int unsigned SEL_W = 4;
    localparam int unsigned N     = 16;

    typedef enum logic {
        FILL,
        HOLD
    } state_e;

endpackage

// File: rtl/sweep_demux_16_if.sv
// Serial-in / frame-out bundle between the sweep receiver and its neighbours.
interface sweep_demux_16_if;
    import sweep_pkg::*;

    logic             in_bit;
    logic             in_valid;
    logic             in_start;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     data_out;
    logic             out_valid;
    logic             out_ready;
    logic             resync_err;

    modport slave (
        input  in_bit, in_valid, in_start, out_ready,
        output in_ready, sel, data_out, out_valid, resync_err
    );

    modport master (
        output in_bit, in_valid, in_start, out_ready,
        input  in_ready, sel, data_out, out_valid, resync_err
    );

endinterface

// File: rtl/sweep_demux_16_slot_counter.sv
// Slot counter: clear has priority over load-to-1 (frame start), which beats increment.
module sweep_slot_counter
    import sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             load1_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             at_last_o
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    always_comb begin
        sel_d = sel_q;
        if (clr_i) begin
            sel_d = '0;
        end else if (load1_i) begin
            sel_d = SEL_W'(1);
        end else if (inc_i) begin
            sel_d = sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel_o     = sel_q;
    assign at_last_o = (sel_q == LAST);

endmodule

// File: rtl/sweep_demux_16.sv
// Receive end of the 16:1 sweep: steers serial bits into frame slots and
// presents completed frames on a double-buffered valid/ready output.
module sweep_demux_16
    import sweep_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sweep_demux_16_if.slave   bus
);

    state_e           state_q, state_d;
    logic [N-1:0]     asm_q, asm_d;
    logic [N-1:0]     data_q, data_d;
    logic             ov_q, ov_d;
    logic             err_q, err_d;

    logic             cnt_inc, cnt_load1, cnt_clr;
    logic [SEL_W-1:0] sel;
    logic             at_last;
    logic             accept;
    logic             out_free;

    sweep_slot_counter u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (cnt_inc),
        .load1_i   (cnt_load1),
        .clr_i     (cnt_clr),
        .sel_o     (sel),
        .at_last_o (at_last)
    );

    assign accept   = bus.in_valid && (state_q == FILL);
    assign out_free = !ov_q || bus.out_ready;

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        data_d    = data_q;
        ov_d      = ov_q && !bus.out_ready;
        err_d     = 1'b0;
        cnt_inc   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clr   = 1'b0;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (bus.in_start) begin
                        // Realign: drop any partial frame; unwritten slots read as zero.
                        asm_d     = '0;
                        asm_d[0]  = bus.in_bit;
                        cnt_load1 = 1'b1;
                        err_d     = (sel != '0);
                    end else begin
                        asm_d[sel] = bus.in_bit;
                        if (!at_last) begin
                            cnt_inc = 1'b1;
                        end else if (out_free) begin
                            data_d  = asm_d;
                            ov_d    = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                // out_valid is necessarily high here, so out_ready alone is a consume.
                if (bus.out_ready) begin
                    data_d  = asm_q;
                    ov_d    = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            asm_q   <= '0;
            data_q  <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready   = (state_q == FILL);
    assign bus.sel        = sel;
    assign bus.data_out   = data_q;
    assign bus.out_valid  = ov_q;
    assign bus.resync_err = err_q;

endmodule

// File: tb/tb_sweep_demux_16.sv
// Directed bench for sweep_demux_16: expected frames go into a scoreboard
// queue when sent and are compared whenever the consumer takes a frame.
module tb_sweep_demux_16;
    import sweep_pkg::*;

    logic clk;
    logic rst;

    sweep_demux_16_if bus ();

    sweep_demux_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned err_pulses = 0;
    int unsigned ov_cycles = 0;
    int unsigned ready_drops = 0;
    bit          streaming = 1'b0;
    logic [15:0] exp_q[$];
    int unsigned ov_times[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every consumed frame must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.resync_err) err_pulses++;
            if (streaming && !bus.in_ready) ready_drops++;
            if (bus.out_valid) begin
                ov_cycles++;
                ov_times.push_back(cyc);
                if (bus.out_ready) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL sb_unexpected observed=%0h required=none", bus.data_out);
                    end
                    if (exp_q.size() != 0) begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        chk("sb_frame", 32'(bus.data_out), 32'(e));
                    end
                end
            end
        end
    end

    task automatic beat(input logic b, input logic st);
        int unsigned n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $error("FAIL beat_timeout observed=in_ready0 required=in_ready1");
        end
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_start = st;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        bus.in_bit   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f, input bit st);
        for (int i = 0; i < 16; i++) beat(f[i], st && (i == 0));
    endtask

    initial begin
        int unsigned e0, ov0, c0;
        rst = 1'b0;
        bus.out_ready = 1'b0;
        idle();

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_data", 32'(bus.data_out), 32'h0);
        chk("rst_ov", 32'(bus.out_valid), 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // Single frame, LSB first.
        bus.out_ready = 1'b1;
        e0 = err_pulses;
        exp_q.push_back(16'hB2D1);
        send_frame(16'hB2D1, 1'b1);
        idle();
        chk("single_ov", 32'(bus.out_valid), 32'h1);
        chk("single_data", 32'(bus.data_out), 32'hB2D1);
        @(posedge clk); #1;
        chk("single_noerr", err_pulses - e0, 0);

        // Backpressure: second frame parks in HOLD.
        bus.out_ready = 1'b0;
        exp_q.push_back(16'h00FF);
        exp_q.push_back(16'hA5A5);
        send_frame(16'h00FF, 1'b0);
        send_frame(16'hA5A5, 1'b0);
        idle();
        chk("bp_hold_ready", 32'(bus.in_ready), 32'h0);
        chk("bp_hold_data", 32'(bus.data_out), 32'h00FF);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_stable_data", 32'(bus.data_out), 32'h00FF);
        chk("bp_stable_ov", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_data", 32'(bus.data_out), 32'hA5A5);
        chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
        chk("bp_release_sel", 32'(bus.sel), 32'h0);
        chk("bp_release_ov", 32'(bus.out_valid), 32'h1);
        @(posedge clk); #1;
        chk("bp_drained", exp_q.size(), 0);

        // Resync: in_start after 5 bits discards the partial frame.
        e0 = err_pulses;
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        chk("rs_sel5", 32'(bus.sel), 32'h5);
        exp_q.push_back(16'h0001);
        beat(1'b1, 1'b1);
        chk("rs_sel1", 32'(bus.sel), 32'h1);
        for (int i = 0; i < 15; i++) beat(1'b0, 1'b0);
        idle();
        chk("rs_data", 32'(bus.data_out), 32'h0001);
        @(posedge clk); #1;
        chk("rs_err_once", err_pulses - e0, 1);

        // Reset mid-frame leaves no stale bits or spurious output.
        @(posedge clk); #1;
        ov0 = ov_cycles;
        for (int i = 0; i < 9; i++) beat(1'b1, 1'b0);
        idle();
        #1 rst = 1'b1;
        #1;
        chk("mr_sel", 32'(bus.sel), 32'h0);
        chk("mr_ov", 32'(bus.out_valid), 32'h0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, 1'b0);
        idle();
        chk("mr_data", 32'(bus.data_out), 32'h1234);
        repeat (2) @(posedge clk);
        #1;
        chk("mr_ov_count", ov_cycles - ov0, 1);

        // Streaming: three frames back-to-back at one bit per cycle.
        ov_times.delete();
        ov0 = ov_cycles;
        c0 = cyc;
        streaming = 1'b1;
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h8001);
        send_frame(16'hFFFF, 1'b1);
        send_frame(16'h0000, 1'b0);
        send_frame(16'h8001, 1'b0);
        idle();
        streaming = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("st_no_drop", ready_drops, 0);
        chk("st_ov_count", ov_cycles - ov0, 3);
        chk("st_times_n", ov_times.size(), 3);
        if (ov_times.size() == 3) begin
            chk("st_t0", ov_times[0] - c0, 16);
            chk("st_t1", ov_times[1] - c0, 32);
            chk("st_t2", ov_times[2] - c0, 48);
        end
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sweep_demux_16.md
Name: sweep_demux_16

Overview:
Receive end of the 16:1 time-division select path. A serial stream produced by sweeping a mux select 0..15 arrives one bit per accepted beat. This block steers each bit into slot[sel] of a 16-bit frame, auto-advancing the slot counter. It presents each completed frame on a valid/ready output, double-buffered so the next frame can assemble while the previous one waits.

Parameters:
N, 16, frame width (number of slots); must equal 2**SEL_W
SEL_W, 4, slot counter width

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
in_bit  input  1  serial data bit for current slot
in_valid  input  1  in_bit valid this cycle
in_start  input  1  qualified by in_valid; marks bit as slot 0 (frame realign)
in_ready  output  1  block can accept a bit this cycle
sel  output  SEL_W  slot the next accepted bit lands in
data_out  output  N  completed frame; bit k = bit received in slot k
out_valid  output  1  data_out holds an unconsumed frame
out_ready  input  1  consumer takes frame when out_valid & out_ready
resync_err  output  1  one-cycle pulse: in_start accepted while sel != 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, takes effect immediately): state=FILL, sel=0, assembly reg asm=0, data_out=0, out_valid=0, resync_err=0. Outputs are registered, except in_ready, which is decoded from state.
- Accept = in_valid & in_ready.
- State FILL: in_ready=1.
  - Accept, no in_start: asm[sel] <= in_bit.
    - If sel != N-1: sel <= sel+1.
    - If sel == N-1 (frame complete):
      - If output is free (!out_valid, or out_valid & out_ready this cycle): data_out <= asm with slot N-1 = in_bit; out_valid <= 1; sel <= 0; stay FILL.
      - Otherwise: asm[N-1] <= in_bit; go HOLD; sel stays N-1.
  - Accept with in_start: asm <= 0 with asm[0] = in_bit; sel <= 1. If prior sel != 0, resync_err=1 the next cycle and the partial frame is discarded. An in_start on a beat where sel == 0 is legal and silent.
- State HOLD: in_ready=0; in_valid and in_start are ignored. When out_ready is 1 in a cycle: data_out <= asm, out_valid stays 1, sel <= 0, go FILL.
- Output handshake: out_valid stays high and data_out stays stable until out_valid & out_ready. On consume with no new frame transferring the same cycle, out_valid <= 0 and data_out holds its value.
- Latency: the last bit accepted in cycle t gives data_out/out_valid in cycle t+1 when the output is free. From HOLD, out_ready in cycle t gives the new frame in cycle t+1.
- Throughput: back-to-back frames with out_ready held high run at one bit per cycle with no bubble.
- Slots not rewritten after a resync are zero, because asm is cleared at in_start. asm is not cleared at normal frame completion; every slot is overwritten anyway.
- Reset mid-frame or in HOLD: all state is discarded and the block returns to reset values; there is no partial-frame output.
- sel wraps only through the completion path; it never exceeds N-1.

Decomposition:
- Shared package sweep_pkg: N, SEL_W, state enum {FILL, HOLD}. The same constants are used by the mux-side sweep generator.
- One natural sub-module: sweep_slot_counter. It is the SEL_W-bit counter with inc, load-to-1 on start, clear, and an at_last flag.
- Frame and handshake logic stays in the top.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> sel=0, data_out=0x0000, out_valid=0, in_ready=1 immediately.
- Single frame: in_start on the first beat, 16 consecutive bits of 0xB2D1 sent LSB (slot 0) first, out_ready=1 -> out_valid=1 with data_out=0xB2D1 one cycle after the 16th beat; resync_err never pulses.
- Backpressure: send frame 0x00FF, hold out_ready=0, then send frame 0xA5A5 -> after 16 beats in_ready=0 (HOLD) and data_out stays 0x00FF. Raise out_ready -> next cycle data_out=0xA5A5, in_ready=1, sel=0.
- Resync: send 5 bits of 1, then in_start with in_bit=1 followed by 15 bits of 0 -> resync_err pulses once; data_out=0x0001.
- Reset mid-frame: 9 bits accepted, then rst pulse, then a full frame 0x1234 -> data_out=0x1234 with no stale bits and no earlier out_valid.
- Streaming: 3 frames back-to-back (0xFFFF, 0x0000, 0x8001), out_ready=1 -> in_ready never drops; out_valid pulses exactly at cycles 17, 33 and 49 with the correct data.
